tdm_demux_1to16: RTL
====================

Name: tdm_demux_1to16

Overview:
- Receive side of the team's 16:1 channel-multiplexing path: accepts a serial stream of W-bit words, time-division multiplexed over 16 channels, and distributes the words back to 16 parallel channel registers.
- Word order within a frame is fixed: channel 0 first, channel 15 last. A frame-start marker flags the channel-0 word.
- Completed frames are double-buffered and presented on a valid/ready output handshake.
- Backpressure reaches the input only when both buffers are occupied.

Parameters:
- W, 1, width of each channel word in bits.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept an input word.
- in_data  input  W  input word.
- in_sof  input  1  start-of-frame; qualified by in_valid && in_ready; marks the channel-0 word.
- frame_valid  output  1  completed frame held on frame_data.
- frame_ready  input  1  consumer accepts the frame.
- frame_data  output  16*W  channel k occupies bits [k*W +: W].
- ch_strobe  output  16  one-hot, one-cycle pulse: channel k written to the working buffer this cycle.
- locked  output  1  aligned to frame boundaries.
- sync_err  output  1  one-cycle pulse on an alignment error.

Behaviour:
- Reset (async assert, sync deassert assumed externally) clears:
  - all outputs to 0, except in_ready = 1;
  - state = HUNT, channel counter = 0, both buffers = 0.
- Input transfer: occurs on a clk edge when in_valid && in_ready. in_data is ignored otherwise.
- State HUNT:
  - Words without in_sof are discarded; no strobe.
  - A word with in_sof is written to working[0], counter becomes 1, state goes to LOCKED, locked = 1 from the next cycle.
- State LOCKED:
  - Each transfer writes working[counter], pulses ch_strobe[counter] in the same cycle, and increments counter (4-bit, wraps 15 to 0).
- Misalignment:
  - in_sof with counter != 0, or no in_sof with counter == 0, pulses sync_err the cycle after the transfer.
  - The word is discarded, working is cleared, counter = 0, state = HUNT, locked = 0.
  - Exception: in_sof with counter != 0 restarts alignment immediately. The word goes to working[0], counter = 1, and the state stays LOCKED. sync_err still pulses.
- Frame completion: writing channel 15 completes the frame.
  - If the output buffer is empty, or is being drained this cycle (frame_valid && frame_ready), working copies to frame_data on the next edge and frame_valid = 1.
  - Otherwise the frame is held in working, counter = 0, and in_ready drops to 0 until the output buffer drains. The held frame then transfers in the drain cycle, and in_ready returns to 1 the following cycle.
- Latency: frame_valid rises one cycle after the channel-15 transfer when the output buffer is free.
- Output handshake:
  - frame_valid && frame_ready clears frame_valid unless a new frame loads in the same edge, in which case frame_valid stays 1 with new data.
  - frame_data is stable while frame_valid && !frame_ready.
- in_ready depends only on registered state, never combinationally on in_valid.

Optional Feature:
- Macro: TDM_DEMUX_STATS_EN.
- With the macro defined:
  - extra output err_count, 8 bits, counts sync_err pulses and saturates at 255, reset 0;
  - extra input err_clr, 1 bit, synchronous clear with priority over increment.
- Without the macro: neither port exists and behaviour is otherwise identical.

Decomposition:
- Package tdm_demux_pkg holds:
  - NUM_CH = 16, SEL_W = 4;
  - state enum {HUNT, LOCKED};
  - a function for the channel bit offset k*W.
- One sub-module, demux_dec_4to16: combinational 4-bit select plus enable to one-hot 16-bit write-enable decoder. It drives both ch_strobe and the working-buffer write enables.

Test Plan:
- Reset mid-frame: drive 5 words after in_sof, assert rst_n = 0 → every output is 0 immediately and in_ready = 1; after release, a word without sof is discarded and state remains HUNT.
- Aligned frame: W = 8, words 0x00..0x0F with sof on the first word, frame_ready = 1 → ch_strobe walks bit 0..15, frame_valid is high one cycle after word 15, frame_data[k*8 +: 8] = k.
- Back-to-back with stall: frame_ready = 0, send two full frames → first frame is held, second completes with in_ready = 0; raise frame_ready for one cycle → frame_data changes to the second frame while frame_valid stays 1, and in_ready = 1 the next cycle.
- Early sof: sof at channel 7 → sync_err pulses once, the word lands in channel 0, locked stays 1, and the next 15 words complete the frame.
- Missing sof: word at counter 0 without sof → sync_err pulses, locked = 0, ch_strobe stays 0 until the next sof.
- Stats (macro defined): force 300 errors → err_count = 255; err_clr with a simultaneous error → 0.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared constants, state type and helpers for the 1:16 TDM demultiplexer.
package tdm_demux_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Bit offset of channel k inside a packed frame of w-bit words.
  function automatic int ch_offset(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/demux_dec_4to16.sv
// Combinational select-plus-enable to one-hot decoder for channel write enables.
module demux_dec_4to16
  import tdm_demux_pkg::*;
(
  input  logic [SEL_W-1:0]  sel,
  input  logic              en,
  output logic [NUM_CH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux_1to16.sv
// Receive side of the 16:1 TDM path: rebuilds frames from a serial word stream
// and double-buffers them. Define TDM_DEMUX_STATS_EN for the err_count/err_clr ports.
module tdm_demux_1to16
  import tdm_demux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  input  logic                in_sof,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [NUM_CH*W-1:0] frame_data,
  output logic [NUM_CH-1:0]   ch_strobe,
  output logic                locked,
  output logic                sync_err
`ifdef TDM_DEMUX_STATS_EN
  ,
  output logic [7:0]          err_count,
  input  logic                err_clr
`endif
);

  localparam int FRAME_W = NUM_CH * W;

  state_t             state;
  logic [SEL_W-1:0]   count;
  logic               held;
  logic [FRAME_W-1:0] working;
  logic [FRAME_W-1:0] working_next;

  logic             xfer;
  logic             at_ch0;
  logic             early_sof;
  logic             missing_sof;
  logic             err_det;
  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic             frame_done;
  logic             drain;
  logic             out_free;

  // A held frame occupies the working buffer, so input stalls until it moves out.
  assign in_ready = !held;

  assign xfer        = in_valid && in_ready;
  assign at_ch0      = (count == '0);
  assign early_sof   = (state == LOCKED) && xfer && in_sof && !at_ch0;
  assign missing_sof = (state == LOCKED) && xfer && !in_sof && at_ch0;
  assign err_det     = early_sof || missing_sof;

  // An sof word always lands in channel 0, whether it locks, continues or restarts alignment.
  assign wr_en      = rst_n && xfer && (in_sof || ((state == LOCKED) && !at_ch0));
  assign wr_sel     = in_sof ? '0 : count;
  assign frame_done = wr_en && (wr_sel == LAST_CH);

  assign drain    = frame_valid && frame_ready;
  assign out_free = !frame_valid || frame_ready;

  demux_dec_4to16 u_dec (
    .sel    (wr_sel),
    .en     (wr_en),
    .onehot (ch_strobe)
  );

  always_comb begin
    working_next = err_det ? '0 : working;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_strobe[k]) working_next[ch_offset(k, W) +: W] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) working <= '0;
    else        working <= working_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      count       <= '0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      held        <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else begin
      sync_err <= err_det;

      if (xfer) begin
        unique case (state)
          HUNT: begin
            if (in_sof) begin
              state  <= LOCKED;
              locked <= 1'b1;
              count  <= SEL_W'(1);
            end
          end
          LOCKED: begin
            if (missing_sof) begin
              state  <= HUNT;
              locked <= 1'b0;
              count  <= '0;
            end else if (in_sof) begin
              count <= SEL_W'(1);
            end else begin
              count <= count + 1'b1;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            count  <= '0;
          end
        endcase
      end

      // The output buffer is refilled in the same edge it drains, so valid never dips.
      if (held) begin
        if (drain) begin
          frame_data <= working;
          held       <= 1'b0;
        end
      end else if (frame_done) begin
        if (out_free) begin
          frame_data  <= working_next;
          frame_valid <= 1'b1;
        end else begin
          held <= 1'b1;
        end
      end else if (drain) begin
        frame_valid <= 1'b0;
      end
    end
  end

`ifdef TDM_DEMUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        err_count <= '0;
    else if (err_clr)                  err_count <= '0;
    else if (err_det && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule
